sync_fifo_ctrl: RTL and testbench

//  Single-clock FIFO; successor to the dual-clock FIFO for same-domain buffering. Adds any-integer

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_mem_1clk.sv | 38 +++
 rtl/sync_fifo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO (sync_fifo_ctrl).
// Optional sticky error flags are compiled in when SYNC_FIFO_ERR_EN is defined.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W  = $clog2(DEF_DEPTH + 1);

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so that non-power-of-2 depths never address past the last word.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem_1clk.sv
// DEPTH x DWIDTH simple dual-port RAM with a registered, read-enabled output.
// Only the output register is reset so the array still maps onto block RAM.
module fifo_mem_1clk #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Output holds its value between reads; the FIFO relies on that for rd_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: any depth, fill count, programmable thresholds, optional FWFT.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DWIDTH            = 64,
  parameter int DEPTH             = 16,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DWIDTH-1:0]          wr_data,
  output logic                       wr_full,
  input  logic                       rd_en,
  output logic [DWIDTH-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       prog_full,
  output logic                       prog_empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int         ADDR_W = addr_w(DEPTH);
  localparam int         CNT_W  = cnt_w(DEPTH);
  localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PF_CNT   = CNT_W'(PROG_FULL_THRESH);
  localparam logic [CNT_W-1:0] PE_CNT   = CNT_W'(PROG_EMPTY_THRESH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_rd_valid;
  logic              r_prog_full;
  logic              r_prog_empty;

  logic [CNT_W-1:0]  w_count_next;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_mem_re;
  logic              w_empty_next;
  logic              w_rd_valid_next;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // The RAM output register doubles as the head register; count covers it too.
      logic r_head_valid;
      logic w_ram_has_word;
      logic w_head_valid_next;

      assign w_ram_has_word    = r_count > CNT_W'(r_head_valid);
      assign w_mem_re          = w_ram_has_word & (~r_head_valid | w_rd_acc);
      assign w_head_valid_next = w_mem_re | (r_head_valid & ~w_rd_acc);
      assign w_empty_next      = ~w_head_valid_next;
      assign w_rd_valid_next   = w_head_valid_next;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_head_valid <= 1'b0;
        end else begin
          r_head_valid <= w_head_valid_next;
        end
      end
    end else begin : g_std
      assign w_mem_re        = w_rd_acc;
      assign w_empty_next    = (w_count_next == '0);
      assign w_rd_valid_next = w_rd_acc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_rd_valid   <= 1'b0;
      r_prog_full  <= 1'b0;
      r_prog_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ADDR_W'(next_ptr(32'(r_wr_ptr), DEPTH));
      end
      if (w_mem_re) begin
        r_rd_ptr <= ADDR_W'(next_ptr(32'(r_rd_ptr), DEPTH));
      end
      r_count      <= w_count_next;
      r_full       <= (w_count_next == FULL_CNT);
      r_empty      <= w_empty_next;
      r_rd_valid   <= w_rd_valid_next;
      r_prog_full  <= (w_count_next >= PF_CNT);
      r_prog_empty <= (w_count_next <= PE_CNT);
    end
  end

  fifo_mem_1clk #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_en   (w_mem_re),
    .rd_addr (r_rd_ptr),
    .rd_data (rd_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en & r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign wr_full    = r_full;
  assign rd_empty   = r_empty;
  assign rd_valid   = r_rd_valid;
  assign count      = r_count;
  assign prog_full  = r_prog_full;
  assign prog_empty = r_prog_empty;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) r_count <= FULL_CNT);
  a_wr_ptr_bound : assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, r_wr_ptr} < (ADDR_W+1)'(DEPTH));
  a_rd_ptr_bound : assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, r_rd_ptr} < (ADDR_W+1)'(DEPTH));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: three instances (16/std, 5/std, 16/FWFT) share one random stimulus.
// Covers overflow/underflow too when SYNC_FIFO_ERR_EN is defined.
`timescale 1ns/1ps
module tb_sync_fifo_ctrl;

  localparam int DW = 16;
  localparam int NI = 3;
  localparam int MQ = 64;

  function automatic int dep_of(input int i);
    case (i)
      1:       return 5;
      default: return 16;
    endcase
  endfunction

  function automatic int fw_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int pf_of(input int i);
    return (i == 1) ? 4 : 12;
  endfunction

  function automatic int pe_of(input int i);
    return (i == 1) ? 1 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wr_data;

  logic          d_full  [NI];
  logic          d_empty [NI];
  logic          d_valid [NI];
  logic          d_pf    [NI];
  logic          d_pe    [NI];
  logic [DW-1:0] d_data  [NI];
  logic [7:0]    d_count [NI];
`ifdef SYNC_FIFO_ERR_EN
  logic          d_ov    [NI];
  logic          d_un    [NI];
`endif

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int D = dep_of(gi);
      logic [$clog2(D+1)-1:0] w_cnt;

      sync_fifo_ctrl #(
        .DWIDTH            (DW),
        .DEPTH             (D),
        .FWFT              (fw_of(gi)),
        .PROG_FULL_THRESH  (pf_of(gi)),
        .PROG_EMPTY_THRESH (pe_of(gi))
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (d_full[gi]),
        .rd_en      (rd_en),
        .rd_data    (d_data[gi]),
        .rd_valid   (d_valid[gi]),
        .rd_empty   (d_empty[gi]),
        .count      (w_cnt),
        .prog_full  (d_pf[gi]),
        .prog_empty (d_pe[gi])
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow   (d_ov[gi]),
        .underflow  (d_un[gi])
`endif
      );

      assign d_count[gi] = 8'(w_cnt);
    end
  endgenerate

  // Reference model: FIFO contents as a ring of (data, write-edge) pairs.
  logic [DW-1:0] m_data [NI][MQ];
  int            m_t    [NI][MQ];
  int            m_head [NI];
  int            m_tail [NI];
  int            m_ann  [NI];
  bit            m_rv   [NI];
  bit            m_ov   [NI];
  bit            m_un   [NI];
  // Scoreboard of expected read words.
  logic [DW-1:0] e_data [NI][MQ];
  int            e_wr   [NI];
  int            e_rd   [NI];
  int            e_base [NI];

  int edge_n = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  function automatic int m_size(input int i);
    return m_tail[i] - m_head[i];
  endfunction

  // FWFT: a word becomes visible once a full cycle has passed since its write edge.
  function automatic bit m_vis(input int i, input int cyc);
    if (m_tail[i] == m_head[i]) return 1'b0;
    if (fw_of(i) == 0) return 1'b1;
    return m_t[i][m_head[i] % MQ] <= cyc - 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, i, edge_n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < NI; i++) begin
      bit full_pre;
      bit vis_pre;
      bit acc_w;
      bit acc_r;
      if (!rst_n) begin
        m_head[i] = 0;
        m_tail[i] = 0;
        m_ann[i]  = 0;
        m_rv[i]   = 1'b0;
        m_ov[i]   = 1'b0;
        m_un[i]   = 1'b0;
        e_base[i] = e_wr[i];
      end else begin
        full_pre = (m_size(i) == dep_of(i));
        vis_pre  = m_vis(i, edge_n - 1);
        acc_w    = wr_en && !full_pre;
        acc_r    = rd_en && vis_pre;
        if (wr_en && full_pre) m_ov[i] = 1'b1;
        if (rd_en && !vis_pre) m_un[i] = 1'b1;
        m_rv[i] = 1'b0;
        if (acc_r) begin
          if (fw_of(i) == 0) begin
            e_data[i][e_wr[i] % MQ] = m_data[i][m_head[i] % MQ];
            e_wr[i] = e_wr[i] + 1;
            m_rv[i] = 1'b1;
          end
          m_head[i] = m_head[i] + 1;
        end
        if (acc_w) begin
          m_data[i][m_tail[i] % MQ] = wr_data;
          m_t[i][m_tail[i] % MQ]    = edge_n;
          m_tail[i] = m_tail[i] + 1;
        end
        if (fw_of(i) != 0 && m_vis(i, edge_n) && m_ann[i] == m_head[i]) begin
          e_data[i][e_wr[i] % MQ] = m_data[i][m_head[i] % MQ];
          e_wr[i]  = e_wr[i] + 1;
          m_ann[i] = m_head[i] + 1;
        end
      end
    end
  end

  // Monitor: flags every cycle, data popped from the scoreboard whenever rd_valid is seen.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        if (e_rd[i] < e_base[i]) e_rd[i] = e_base[i];
        chk("wr_full", i, 32'(d_full[i]), 32'(m_size(i) == dep_of(i)));
        chk("rd_empty", i, 32'(d_empty[i]), 32'(!m_vis(i, edge_n)));
        chk("rd_valid", i, 32'(d_valid[i]), 32'((fw_of(i) != 0) ? m_vis(i, edge_n) : m_rv[i]));
        chk("count", i, 32'(d_count[i]), 32'(m_size(i)));
        chk("prog_full", i, 32'(d_pf[i]), 32'(m_size(i) >= pf_of(i)));
        chk("prog_empty", i, 32'(d_pe[i]), 32'(m_size(i) <= pe_of(i)));
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow", i, 32'(d_ov[i]), 32'(m_ov[i]));
        chk("underflow", i, 32'(d_un[i]), 32'(m_un[i]));
`endif
        if (d_valid[i] === 1'b1) begin
          if (e_rd[i] >= e_wr[i]) begin
            chk("rd_data_unexpected", i, 32'(d_data[i]), 32'hFFFF_FFFF);
          end else begin
            chk("rd_data", i, 32'(d_data[i]), 32'(e_data[i][e_rd[i] % MQ]));
            if (fw_of(i) == 0 || rd_en) e_rd[i] = e_rd[i] + 1;
          end
        end
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int cycles);
    int wp;
    for (int c = 0; c < cycles; c++) begin
      case ((c / 64) % 3)
        0:       wp = 75;
        1:       wp = 25;
        default: wp = 50;
      endcase
      drive($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), DW'($urandom));
    end
  endtask

  initial begin
    int rd_eff;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, DW'(k));
    repeat (2) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 16'h0077);
    repeat (2) drive(1'b0, 1'b0, '0);
    repeat (20) drive(1'b0, 1'b1, '0);

    drive(1'b1, 1'b0, 16'h00A5);
    repeat (3) drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);

    for (int lap = 0; lap < 3; lap++) begin
      for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, DW'(lap * 16 + k + 16'h100));
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, '0);
    end
    repeat (4) drive(1'b0, 1'b1, '0);

    rand_run(1200);

    repeat (20) drive(1'b0, 1'b1, '0);
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, DW'(16'h200 + k));
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'hDEAD);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, '0);

    rand_run(600);
    repeat (25) drive(1'b0, 1'b1, '0);
    repeat (3) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < NI; i++) begin
      rd_eff = (e_rd[i] < e_base[i]) ? e_base[i] : e_rd[i];
      chk("scoreboard_left", i, 32'(e_wr[i] - rd_eff), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
